uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares the single UART transmit FIFO write port among NUM_REQ byte-stream requesters.
// - Round-robin grant at packet granularity; a granted requester keeps the FIFO until its
//   last byte or MAX_BURST bytes, whichever comes first. Each packet reaches the serial line
//   contiguous.
// - Sits in the clk domain, upstream of the TX FIFO write side. It drives wr_en/data_in and
//   observes full.
// PARAMETERS
// - NUM_REQ    4   number of requesters (2..8)
// - DATA_W     8   byte width, matches UART frame payload
// - MAX_BURST  16  max bytes per grant before forced rotation (1..255)
// PORTS
// - clk         in   1                system clock (same clock as TX FIFO write side)
// - reset_n     in   1                asynchronous, active-low reset
// - req_valid   in   NUM_REQ          per-requester byte valid
// - req_data    in   NUM_REQ*DATA_W   per-requester byte; requester i at [i*DATA_W +: DATA_W]
// - req_last    in   NUM_REQ          byte is last of packet (qualified by valid)
// - req_ready   out  NUM_REQ          byte accepted this cycle when valid&ready
// - fifo_full   in   1                TX FIFO full flag
// - fifo_wr_en  out  1                TX FIFO write enable
// - fifo_data   out  DATA_W           TX FIFO write data
// - grant_id    out  clog2(NUM_REQ)   current/last granted requester
// - busy        out  1                high while in XFER
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE; ptr=NUM_REQ-1 so requester 0 wins first;
//   burst_cnt=0; grant_id=0; busy=0; req_ready=0; fifo_wr_en=0; fifo_data=0.
// - FSM IDLE -> XFER -> IDLE.
//   - IDLE: if any req_valid, pick first set valid scanning ptr+1, ptr+2, ... (mod NUM_REQ).
//     Register grant_id, set busy, clear burst_cnt, go XFER next cycle.
//     1-cycle arbitration bubble per grant.
//   - XFER (g=grant_id): req_ready[g]=~fifo_full; all other ready bits 0. Combinational:
//     fifo_wr_en=req_valid[g]&~fifo_full, fifo_data=req_data[g] (0 when fifo_wr_en=0).
//   - Beat = fifo_wr_en. On a beat burst_cnt++. Beat with req_last[g] or burst_cnt==MAX_BURST-1
//     -> ptr<=g, go IDLE.
// - Packet lock: in XFER, req_valid[g] low or fifo_full high = stall, grant held, no timeout.
// - Full: never assert fifo_wr_en while fifo_full=1 (zero overflow, zero-latency backpressure).
// - Forced rotation at MAX_BURST: the remainder of that packet re-arbitrates normally.
//   Packet contiguity is only guaranteed for packets <= MAX_BURST.
// - Simultaneous requests: rotation guarantees each active requester a grant within NUM_REQ
//   grants.
// - req_last without req_valid is ignored. req_data of non-granted requesters is ignored.
// - Reset mid-XFER: grant dropped immediately, no partial write. Any partial packet stays
//   partial.
// - Throughput: MAX_BURST bytes per MAX_BURST+1 cycles max. Far above baud rate, so the
//   bubble is irrelevant.
// STRUCTURE
// - Shared package uart_pkg: UART_DATA_W=8; typedef for FSM state {IDLE, XFER}.
// - Sub-module rr_arbiter (NUM_REQ): combinational, inputs req vector + ptr, outputs grant
//   index + any. Reusable for RX-side fan-out.
// - Top: FSM, burst counter, grant mux. Outputs registered except ready/wr_en/data
//   (combinational from grant).
// TESTING
// - Reset, req_valid=4'b1111, each sends one 1-byte packet (0xA0..0xA3, last=1)
//   -> FIFO order A0,A1,A2,A3; grant_id 0,1,2,3.
// - Req1 sends 3-byte packet 11,22,33, req2 valid throughout with 0x55
//   -> FIFO gets 11,22,33 then 55; no interleave.
// - Req0 20-byte packet, MAX_BURST=16, req3 waiting
//   -> 16 bytes of req0, then req3 packet, then remaining 4 of req0.
// - fifo_full high 5 cycles mid-packet -> fifo_wr_en=0, req_ready=0 those cycles;
//   no byte lost or duplicated.
// - Granted requester drops valid 3 cycles mid-packet while others request
//   -> grant held, busy=1, resumes, no switch.
// - reset_n low during XFER -> all outputs 0 same cycle; after release, req0 wins first
//   arbitration.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and the TX arbiter FSM state type.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } tx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick, first set request after ptr.
// Revision : 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    logic [IDX_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest candidate after ptr wins last.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            w_idx = IDX_W'((int'(ptr) + off) % NUM_REQ);
            if (req[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Packet-granular round-robin sharing of the UART TX FIFO write port.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = UART_DATA_W,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_data,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(MAX_BURST - 1);

    tx_state_t         r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_grant_id;
    logic [CNT_W-1:0]  r_burst_cnt;
    logic              r_busy;

    logic [IDX_W-1:0]  w_arb_grant;
    logic              w_arb_any;
    logic              w_beat;
    logic              w_end_grant;
    logic [DATA_W-1:0] w_req_bytes [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (r_ptr),
        .grant (w_arb_grant),
        .any   (w_arb_any)
    );

    assign w_beat      = (r_state == XFER) & req_valid[r_grant_id] & ~fifo_full;
    assign w_end_grant = w_beat & (req_last[r_grant_id] | (r_burst_cnt == C_LAST_CNT));

    // Write path is combinational from the held grant for zero-latency backpressure.
    always_comb begin
        req_ready  = '0;
        fifo_wr_en = w_beat;
        fifo_data  = '0;
        if (r_state == XFER) begin
            req_ready[r_grant_id] = ~fifo_full;
        end
        if (w_beat) begin
            fifo_data = w_req_bytes[r_grant_id];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= IDX_W'(NUM_REQ - 1);
            r_grant_id  <= '0;
            r_burst_cnt <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_grant_id  <= w_arb_grant;
                        r_burst_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= XFER;
                    end
                end
                XFER: begin
                    if (w_beat) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                        if (w_end_grant) begin
                            r_ptr   <= r_grant_id;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = r_busy;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed and randomized packet streams against a queue-level model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;
    localparam int IDX_W     = 2;
    localparam int DEPTH     = 64;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_last;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      fifo_full;
    logic                      fifo_wr_en;
    logic [DATA_W-1:0]         fifo_data;
    logic [IDX_W-1:0]          grant_id;
    logic                      busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [7:0]   src_data [NUM_REQ][DEPTH];
    logic         src_last [NUM_REQ][DEPTH];
    int           src_head [NUM_REQ];
    int           src_tail [NUM_REQ];
    bit [NUM_REQ-1:0] gap;
    int           exp_q[$];
    int           model_ptr;
    int           n_wr = 0;
    bit           rand_full, force_full, chk_stall, chk_hold;
    int           hold_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_sources();
        for (int i = 0; i < NUM_REQ; i++) begin
            src_head[i] = 0;
            src_tail[i] = 0;
        end
        gap = '0;
    endtask

    task automatic push_byte(input int id, input logic [7:0] d, input bit last);
        src_data[id][src_tail[id]] = d;
        src_last[id][src_tail[id]] = last;
        src_tail[id]++;
    endtask

    task automatic add_packet(input int id, input int len, input logic [7:0] base, input bit rnd);
        for (int k = 0; k < len; k++)
            push_byte(id, rnd ? 8'($urandom) : base + 8'(k), k == len - 1);
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < NUM_REQ; i++)
            if (src_head[i] < src_tail[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Packet-level model: rotate over requesters with data, take up to last or MAX_BURST bytes.
    task automatic build_expected();
        int h[NUM_REQ];
        int g, cnt;
        bit found, done;
        for (int i = 0; i < NUM_REQ; i++) h[i] = src_head[i];
        for (int guard = 0; guard < 1000; guard++) begin
            found = 1'b0;
            g = 0;
            for (int off = 1; off <= NUM_REQ; off++) begin
                int c;
                c = (model_ptr + off) % NUM_REQ;
                if (!found && h[c] < src_tail[c]) begin
                    found = 1'b1;
                    g = c;
                end
            end
            if (!found) break;
            cnt = 0;
            done = 1'b0;
            while (!done && h[g] < src_tail[g]) begin
                exp_q.push_back((g << 8) | int'(src_data[g][h[g]]));
                cnt++;
                done = src_last[g][h[g]] || (cnt == MAX_BURST);
                h[g]++;
            end
            model_ptr = g;
        end
    endtask

    task automatic drive();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (src_head[i] < src_tail[i] && !gap[i]) begin
                req_valid[i] = 1'b1;
                req_data[i*DATA_W +: DATA_W] = src_data[i][src_head[i]];
                req_last[i] = src_last[i][src_head[i]];
            end else begin
                req_data[i*DATA_W +: DATA_W] = 8'($urandom);
                req_last[i] = 1'($urandom_range(1));
            end
        end
        fifo_full = force_full | (rand_full && ($urandom_range(2) == 0));
    endtask

    task automatic tick();
        logic [NUM_REQ-1:0] acc;
        int e;
        @(negedge clk);
        acc = req_valid & req_ready;
        check("no_write_when_full", 32'(fifo_wr_en & fifo_full), 0);
        check("accept_matches_write", 32'(acc != '0), 32'(fifo_wr_en));
        if (fifo_wr_en) begin
            n_wr++;
            check("write_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("fifo_data", 32'(fifo_data), e & 8'hFF);
                check("grant_id_on_write", 32'(grant_id), e >> 8);
            end
        end
        if (chk_stall) begin
            check("stall_wr_en", 32'(fifo_wr_en), 0);
            check("stall_ready", 32'(req_ready), 0);
        end
        if (chk_hold) begin
            check("hold_busy", 32'(busy), 1);
            check("hold_grant", 32'(grant_id), hold_id);
            check("hold_wr_en", 32'(fifo_wr_en), 0);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++)
            if (acc[i]) src_head[i]++;
        drive();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || !sources_empty()) && n < 3000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check({tag, "_drained"}, exp_q.size(), 0);
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic wait_writes(input string tag, input int count);
        int w0, n;
        w0 = n_wr;
        n = 0;
        while (n_wr < w0 + count && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_reached_mid"}, 32'(n_wr - w0 >= count), 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_sources();
        exp_q.delete();
        model_ptr = NUM_REQ - 1;
        force_full = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_full = 1'b0; force_full = 1'b0; chk_stall = 1'b0; chk_hold = 1'b0;
        hold_id = 0;
        reset_n   = 1'b0;
        req_valid = '1;
        req_last  = '1;
        req_data  = '1;
        fifo_full = 1'b0;
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_grant_id", 32'(grant_id), 0);
        check("rst_wr_en", 32'(fifo_wr_en), 0);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_data", 32'(fifo_data), 0);
        do_reset();

        // One-byte packets from every requester
        for (int i = 0; i < NUM_REQ; i++) push_byte(i, 8'hA0 + 8'(i), 1'b1);
        build_expected();
        drive();
        drain("t1");

        // Three-byte packet is not interleaved with a competing requester
        push_byte(1, 8'h11, 1'b0);
        push_byte(1, 8'h22, 1'b0);
        push_byte(1, 8'h33, 1'b1);
        push_byte(2, 8'h55, 1'b1);
        build_expected();
        drive();
        drain("t2");

        // Forced rotation after MAX_BURST bytes
        do_reset();
        add_packet(0, 20, 8'h00, 1'b0);
        add_packet(3, 2, 8'hD0, 1'b0);
        build_expected();
        drive();
        drain("t3");

        // FIFO full for five cycles mid-packet
        clear_sources();
        add_packet(2, 8, 8'h40, 1'b0);
        build_expected();
        drive();
        wait_writes("t4", 3);
        force_full = 1'b1;
        chk_stall  = 1'b1;
        drive();
        repeat (5) tick();
        chk_stall  = 1'b0;
        force_full = 1'b0;
        drive();
        drain("t4");

        // Granted requester drops valid for three cycles while others wait
        clear_sources();
        for (int i = 0; i < NUM_REQ; i++) add_packet(i, 6, 8'h60 + 8'(i * 16), 1'b0);
        build_expected();
        drive();
        wait_writes("t5", 2);
        hold_id = exp_q[0] >> 8;
        gap[hold_id] = 1'b1;
        chk_hold = 1'b1;
        drive();
        repeat (3) tick();
        chk_hold = 1'b0;
        gap = '0;
        drive();
        drain("t5");

        // Reset in the middle of a transfer
        clear_sources();
        add_packet(1, 10, 8'h80, 1'b0);
        build_expected();
        drive();
        wait_writes("t6", 4);
        check("t6_busy_before_reset", 32'(busy), 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_wr_en", 32'(fifo_wr_en), 0);
        check("t6_rst_ready", 32'(req_ready), 0);
        check("t6_rst_data", 32'(fifo_data), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_grant", 32'(grant_id), 0);
        do_reset();
        add_packet(1, 2, 8'hB0, 1'b0);
        add_packet(0, 2, 8'hC0, 1'b0);
        add_packet(3, 1, 8'hE0, 1'b0);
        build_expected();
        drive();
        drain("t6");

        // Randomized packet mixes with random FIFO backpressure
        rand_full = 1'b1;
        for (int r = 0; r < 4; r++) begin
            clear_sources();
            for (int i = 0; i < NUM_REQ; i++) begin
                int np;
                np = $urandom_range(2);
                for (int p = 0; p < np; p++)
                    add_packet(i, $urandom_range(20, 1), 8'h00, 1'b1);
            end
            build_expected();
            drive();
            drain("rand");
        end
        rand_full = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
